// File: rtl/peri_bridge_pkg.sv
// Shared peripheral address map and BTN register field layout for the
// bridge and the LED/digit peripherals.
package peri_bridge_pkg;

  localparam logic [19:0] PERI_PAGE     = 20'hFFFFF;
  localparam logic [31:0] PERI_ADDR_DIG = 32'hFFFF_F000;
  localparam logic [31:0] PERI_ADDR_LED = 32'hFFFF_F060;
  localparam logic [31:0] PERI_ADDR_SW  = 32'hFFFF_F070;
  localparam logic [31:0] PERI_ADDR_BTN = 32'hFFFF_F078;

  localparam int BTN_LVL_LSB = 0;
  localparam int BTN_FLG_LSB = 8;

  function automatic logic is_peri(input logic [31:0] addr);
    return addr[31:12] == PERI_PAGE;
  endfunction

endpackage

// File: rtl/peri_bridge_btn_debounce.sv
// One button: two-flop synchroniser, hold-time counter and accepted level,
// plus a combinational pulse on the edge where the accepted level rises.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic stable_o,
  output logic rise_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             meta_q;
  logic             sync_q;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;

  always_comb begin
    accept   = (sync_q != stable_q) && (cnt_q == CNT_LAST);
    stable_d = stable_q;
    cnt_d    = cnt_q;
    if (sync_q == stable_q) begin
      cnt_d = '0;
    end else if (accept) begin
      // Level held long enough: take it and restart from zero.
      stable_d = sync_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q   <= 1'b0;
      sync_q   <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      meta_q   <= btn_i;
      sync_q   <= meta_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable_o = stable_q;
  assign rise_o   = accept & sync_q;

endmodule

// File: rtl/peri_bridge.sv
// CPU data-port bridge: address decode and write steering, read mux,
// switch synchroniser, debounced buttons and sticky W1C press flags.
module peri_bridge
  import peri_bridge_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int SW_W            = 24,
  parameter int BTN_W           = 5
) (
  input  logic              clk_to_bridge,
  input  logic              rst_to_bridge,
  input  logic [31:0]       addr_from_cpu,
  input  logic              we_from_cpu,
  input  logic [31:0]       wdata_from_cpu,
  output logic [31:0]       rdata_to_cpu,
  output logic [31:0]       addr_to_dram,
  output logic [31:0]       wdata_to_dram,
  output logic              we_to_dram,
  input  logic [31:0]       rdata_from_dram,
  output logic [31:0]       addr_to_led,
  output logic [31:0]       wdata_to_led,
  output logic              we_to_led,
  output logic [31:0]       addr_to_dig,
  output logic [31:0]       wdata_to_dig,
  output logic              we_to_dig,
  input  logic [SW_W-1:0]   sw,
  input  logic [BTN_W-1:0]  btn
);

  logic              peri;
  logic [SW_W-1:0]   sw_meta_q;
  logic [SW_W-1:0]   sw_sync_q;
  logic [BTN_W-1:0]  btn_stable;
  logic [BTN_W-1:0]  btn_rise;
  logic [BTN_W-1:0]  flag_q, flag_d;
  logic [BTN_W-1:0]  flag_clr;

  assign peri = is_peri(addr_from_cpu);

  assign addr_to_dram  = addr_from_cpu;
  assign wdata_to_dram = wdata_from_cpu;
  assign addr_to_led   = addr_from_cpu;
  assign wdata_to_led  = wdata_from_cpu;
  assign addr_to_dig   = addr_from_cpu;
  assign wdata_to_dig  = wdata_from_cpu;

  assign we_to_dram = we_from_cpu & ~peri;
  assign we_to_led  = we_from_cpu & (addr_from_cpu == PERI_ADDR_LED);
  assign we_to_dig  = we_from_cpu & (addr_from_cpu == PERI_ADDR_DIG);

  always_comb begin
    rdata_to_cpu = '0;
    if (!peri) begin
      rdata_to_cpu = rdata_from_dram;
    end else if (addr_from_cpu == PERI_ADDR_SW) begin
      rdata_to_cpu[SW_W-1:0] = sw_sync_q;
    end else if (addr_from_cpu == PERI_ADDR_BTN) begin
      rdata_to_cpu[BTN_LVL_LSB +: BTN_W] = btn_stable;
      rdata_to_cpu[BTN_FLG_LSB +: BTN_W] = flag_q;
    end
  end

  // A rising accepted level on the same edge as a clear keeps the flag set.
  always_comb begin
    flag_clr = '0;
    if (we_from_cpu && (addr_from_cpu == PERI_ADDR_BTN)) begin
      flag_clr = wdata_from_cpu[BTN_FLG_LSB +: BTN_W];
    end
    flag_d = (flag_q & ~flag_clr) | btn_rise;
  end

  always_ff @(posedge clk_to_bridge or negedge rst_to_bridge) begin
    if (!rst_to_bridge) begin
      sw_meta_q <= '0;
      sw_sync_q <= '0;
      flag_q    <= '0;
    end else begin
      sw_meta_q <= sw;
      sw_sync_q <= sw_meta_q;
      flag_q    <= flag_d;
    end
  end

  for (genvar i = 0; i < BTN_W; i++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn_debounce (
      .clk_i   (clk_to_bridge),
      .rst_ni  (rst_to_bridge),
      .btn_i   (btn[i]),
      .stable_o(btn_stable[i]),
      .rise_o  (btn_rise[i])
    );
  end

endmodule

// File: tb/tb_peri_bridge.sv
// Directed bench for peri_bridge: decode/read-mux vector table plus
// hand-written sequences for synchroniser, debounce, flags and reset.
module tb_peri_bridge;

  localparam int DC    = 4;
  localparam int SW_W  = 24;
  localparam int BTN_W = 5;

  localparam logic [31:0] A_LED = 32'hFFFF_F060;
  localparam logic [31:0] A_DIG = 32'hFFFF_F000;
  localparam logic [31:0] A_SW  = 32'hFFFF_F070;
  localparam logic [31:0] A_BTN = 32'hFFFF_F078;

  logic              clk;
  logic              rst_n;
  logic [31:0]       addr;
  logic              we;
  logic [31:0]       wdata;
  logic [31:0]       rdata;
  logic [31:0]       addr_to_dram, wdata_to_dram;
  logic              we_to_dram;
  logic [31:0]       rdata_from_dram;
  logic [31:0]       addr_to_led, wdata_to_led;
  logic              we_to_led;
  logic [31:0]       addr_to_dig, wdata_to_dig;
  logic              we_to_dig;
  logic [SW_W-1:0]   sw;
  logic [BTN_W-1:0]  btn;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] dram;
    logic [31:0] exp_rdata;
    logic        exp_we_dram;
    logic        exp_we_led;
    logic        exp_we_dig;
  } vec_t;

  vec_t vecs[10];

  peri_bridge #(
    .DEBOUNCE_CYCLES(DC),
    .SW_W(SW_W),
    .BTN_W(BTN_W)
  ) dut (
    .clk_to_bridge  (clk),
    .rst_to_bridge  (rst_n),
    .addr_from_cpu  (addr),
    .we_from_cpu    (we),
    .wdata_from_cpu (wdata),
    .rdata_to_cpu   (rdata),
    .addr_to_dram   (addr_to_dram),
    .wdata_to_dram  (wdata_to_dram),
    .we_to_dram     (we_to_dram),
    .rdata_from_dram(rdata_from_dram),
    .addr_to_led    (addr_to_led),
    .wdata_to_led   (wdata_to_led),
    .we_to_led      (we_to_led),
    .addr_to_dig    (addr_to_dig),
    .wdata_to_dig   (wdata_to_dig),
    .we_to_dig      (we_to_dig),
    .sw             (sw),
    .btn            (btn)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic read_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
    addr = a;
    we   = 1'b0;
    #1;
    check(name, rdata, exp);
  endtask

  // One-cycle store presented before the next edge; returns just after it.
  task automatic store(input logic [31:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    we    = 1'b1;
    tick(1);
    we    = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    addr = '0; we = 1'b0; wdata = '0;
    rdata_from_dram = '0;
    sw = '0; btn = '0;

    vecs[0] = '{A_LED, 1'b1, 32'h00AB_CDEF, 32'h0,         32'h0,         1'b0, 1'b1, 1'b0};
    vecs[1] = '{A_DIG, 1'b1, 32'h0000_1111, 32'h5,         32'h0,         1'b0, 1'b0, 1'b1};
    vecs[2] = '{32'h0000_0100, 1'b1, 32'h55, 32'h0,        32'h0,         1'b1, 1'b0, 1'b0};
    vecs[3] = '{32'h0000_0100, 1'b0, 32'h0,  32'h1234_5678, 32'h1234_5678, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{A_LED, 1'b0, 32'h0,  32'hDEAD,       32'h0,         1'b0, 1'b0, 1'b0};
    vecs[5] = '{A_DIG, 1'b0, 32'h0,  32'hDEAD,       32'h0,         1'b0, 1'b0, 1'b0};
    vecs[6] = '{A_SW,  1'b1, 32'h77, 32'hDEAD,       32'h0,         1'b0, 1'b0, 1'b0};
    vecs[7] = '{32'hFFFF_F004, 1'b1, 32'h9, 32'hDEAD, 32'h0,        1'b0, 1'b0, 1'b0};
    vecs[8] = '{32'hFFFF_E060, 1'b1, 32'h9, 32'hCAFE, 32'hCAFE,     1'b1, 1'b0, 1'b0};
    vecs[9] = '{A_BTN, 1'b0, 32'h0,  32'hBEEF,       32'h0,         1'b0, 1'b0, 1'b0};

    // Reset state, and write enables stay live while reset is held.
    #12;
    read_chk("rst_sw_read", A_SW, 32'h0);
    read_chk("rst_btn_read", A_BTN, 32'h0);
    addr = A_LED; wdata = 32'h1; we = 1'b1; #1;
    check("rst_we_led", {31'h0, we_to_led}, 32'h1);
    we = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick(1);

    // Decode / read-mux table.
    for (int i = 0; i < 10; i++) begin
      addr = vecs[i].addr;
      we = vecs[i].we;
      wdata = vecs[i].wdata;
      rdata_from_dram = vecs[i].dram;
      #1;
      check($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
      check($sformatf("vec%0d_we_dram", i), {31'h0, we_to_dram}, {31'h0, vecs[i].exp_we_dram});
      check($sformatf("vec%0d_we_led", i), {31'h0, we_to_led}, {31'h0, vecs[i].exp_we_led});
      check($sformatf("vec%0d_we_dig", i), {31'h0, we_to_dig}, {31'h0, vecs[i].exp_we_dig});
      check($sformatf("vec%0d_wdata_led", i), wdata_to_led, vecs[i].wdata);
      check($sformatf("vec%0d_addr_dram", i), addr_to_dram, vecs[i].addr);
      we = 1'b0;
      tick(1);
    end
    rdata_from_dram = '0;

    // Switch synchroniser: two edges.
    sw = 24'hA5A5A5;
    addr = A_SW;
    tick(1);
    read_chk("sw_after_1", A_SW, 32'h0);
    tick(1);
    read_chk("sw_after_2", A_SW, 32'h00A5_A5A5);

    // btn[2] held: first sampled on the next edge, accepted 5 edges later.
    btn = 5'b00100;
    for (int k = 1; k <= 5; k++) begin
      tick(1);
      read_chk($sformatf("btn2_early_%0d", k), A_BTN, 32'h0);
    end
    tick(1);
    read_chk("btn2_accept", A_BTN, 32'h0000_0404);
    store(A_BTN, 32'h0000_0400);
    read_chk("btn2_w1c", A_BTN, 32'h0000_0004);
    btn = 5'b00000;
    tick(5);
    read_chk("btn2_rel_early", A_BTN, 32'h0000_0004);
    tick(1);
    read_chk("btn2_released", A_BTN, 32'h0);

    // Bounce on btn[0]: toggles every 2 cycles, never held long enough.
    for (int k = 0; k < 10; k++) begin
      btn[0] = (k % 2 == 0);
      tick(2);
      read_chk($sformatf("bounce_%0d", k), A_BTN, 32'h0);
    end
    btn[0] = 1'b0;
    tick(8);
    read_chk("bounce_rest", A_BTN, 32'h0);

    // Set and W1C on the same edge: set wins; release leaves the flag.
    btn = 5'b01000;
    tick(5);
    store(A_BTN, 32'h0000_0800);
    read_chk("set_vs_clr", A_BTN, 32'h0000_0808);
    btn = 5'b00000;
    tick(6);
    read_chk("release_keeps_flag", A_BTN, 32'h0000_0800);
    store(A_BTN, 32'h0000_0800);
    read_chk("flag3_cleared", A_BTN, 32'h0);

    // Reset mid-count: everything reads 0 at once, count restarts after.
    btn = 5'b10000;
    tick(6);
    read_chk("btn4_accept", A_BTN, 32'h0000_1010);
    btn = 5'b10010;
    tick(4);
    rst_n = 1'b0;
    read_chk("midrst_btn", A_BTN, 32'h0);
    read_chk("midrst_sw", A_SW, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick(2);
    read_chk("postrst_sw", A_SW, 32'h00A5_A5A5);
    tick(3);
    read_chk("postrst_btn_early", A_BTN, 32'h0);
    tick(1);
    read_chk("postrst_btn_accept", A_BTN, 32'h0000_1212);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
